feed_tick_decoder: RTL

Market-data front end that drives the order book's tick port. Accepts a byte stream of fixed-length binary feed messages over a valid/ready interface and validates framing, type and side. It emits one single-cycle tick (valid, type, side, qty, price) per good message into the book's tick input. Malformed frames are dropped and counted; they never produce a tick.

---
 rtl/feed_tick_decoder_pkg.sv | 31 +++
 rtl/feed_tick_decoder_if.sv | 25 ++
 rtl/feed_tick_decoder_sat_counter.sv | 19 +
 rtl/feed_tick_decoder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/feed_tick_decoder_pkg.sv
// Shared constants, byte codes and FSM encoding for the feed tick decoder.
package feed_tick_decoder_pkg;

    localparam int unsigned FRAME_LEN = 10;
    localparam int unsigned IDX_W     = 4;

    localparam logic [IDX_W-1:0] FIRST_BODY_IDX = IDX_W'(2);
    localparam logic [IDX_W-1:0] LAST_QTY_IDX   = IDX_W'(5);
    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(FRAME_LEN - 1);

    localparam logic [7:0] CODE_ADD    = 8'h41;
    localparam logic [7:0] CODE_CANCEL = 8'h58;
    localparam logic [7:0] CODE_BID    = 8'h42;
    localparam logic [7:0] CODE_ASK    = 8'h53;

    typedef enum logic [1:0] {
        ST_TYPE = 2'd0,
        ST_SIDE = 2'd1,
        ST_BODY = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    function automatic logic is_type_code(input logic [7:0] b);
        return (b == CODE_ADD) || (b == CODE_CANCEL);
    endfunction

    function automatic logic is_side_code(input logic [7:0] b);
        return (b == CODE_BID) || (b == CODE_ASK);
    endfunction

endpackage

// File: rtl/feed_tick_decoder_if.sv
// Byte-stream input and tick output bundle between feed source, decoder and book.
interface feed_tick_decoder_if #(
    parameter int unsigned QTY_W = 32,
    parameter int unsigned PX_W  = 32
);
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_last;
    logic             s_ready;
    logic             tick_valid;
    logic             tick_type;
    logic             tick_side;
    logic [QTY_W-1:0] tick_qty;
    logic [PX_W-1:0]  tick_price;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, tick_valid, tick_type, tick_side, tick_qty, tick_price
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, tick_valid, tick_type, tick_side, tick_qty, tick_price
    );
endinterface

// File: rtl/feed_tick_decoder_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module feed_tick_decoder_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/feed_tick_decoder.sv
// Decodes fixed 10-byte binary feed frames into single-cycle book ticks;
// malformed frames are dropped and counted.
module feed_tick_decoder
    import feed_tick_decoder_pkg::*;
#(
    parameter int unsigned QTY_W = 32,
    parameter int unsigned PX_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    feed_tick_decoder_if.slave   bus,
    output logic [CNT_W-1:0]     msg_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [QTY_W-1:0]   qty_q, qty_d;
    logic [PX_W-1:0]    px_q, px_d;
    logic               type_q, type_d;
    logic               side_q, side_d;
    logic               tick_now;
    logic               msg_inc;
    logic               err_inc;

    // The decoder never backpressures; it only refuses bytes while held in reset.
    assign bus.s_ready = rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_TYPE;
            idx_q          <= '0;
            qty_q          <= '0;
            px_q           <= '0;
            type_q         <= 1'b0;
            side_q         <= 1'b0;
            bus.tick_valid <= 1'b0;
            bus.tick_type  <= 1'b0;
            bus.tick_side  <= 1'b0;
            bus.tick_qty   <= '0;
            bus.tick_price <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            qty_q          <= qty_d;
            px_q           <= px_d;
            type_q         <= type_d;
            side_q         <= side_d;
            bus.tick_valid <= tick_now;
            if (tick_now) begin
                bus.tick_type  <= type_q;
                bus.tick_side  <= side_q;
                bus.tick_qty   <= qty_q;
                bus.tick_price <= px_d;
            end
        end
    end

    // Errors detected mid-frame that go through DROP are counted on the s_last byte,
    // so each bad frame bumps err_cnt exactly once at its terminating handshake.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        qty_d    = qty_q;
        px_d     = px_q;
        type_d   = type_q;
        side_d   = side_q;
        tick_now = 1'b0;
        msg_inc  = 1'b0;
        err_inc  = 1'b0;

        if (bus.s_valid) begin
            unique case (state_q)
                ST_TYPE: begin
                    qty_d = '0;
                    px_d  = '0;
                    idx_d = '0;
                    if (bus.s_last) begin
                        err_inc = 1'b1;
                    end else if (is_type_code(bus.s_data)) begin
                        type_d  = (bus.s_data == CODE_CANCEL);
                        state_d = ST_SIDE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_SIDE: begin
                    if (bus.s_last) begin
                        err_inc = 1'b1;
                        state_d = ST_TYPE;
                    end else if (is_side_code(bus.s_data)) begin
                        side_d  = (bus.s_data == CODE_BID);
                        idx_d   = FIRST_BODY_IDX;
                        state_d = ST_BODY;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_BODY: begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q <= LAST_QTY_IDX) begin
                        qty_d = {qty_q[QTY_W-9:0], bus.s_data};
                    end else begin
                        px_d = {px_q[PX_W-9:0], bus.s_data};
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!bus.s_last) begin
                            state_d = ST_DROP;
                        end else begin
                            state_d = ST_TYPE;
                            if (qty_q == '0) begin
                                err_inc = 1'b1;
                            end else begin
                                tick_now = 1'b1;
                                msg_inc  = 1'b1;
                            end
                        end
                    end else if (bus.s_last) begin
                        err_inc = 1'b1;
                        idx_d   = '0;
                        state_d = ST_TYPE;
                    end
                end
                ST_DROP: begin
                    if (bus.s_last) begin
                        err_inc = 1'b1;
                        state_d = ST_TYPE;
                    end
                end
                default: state_d = ST_TYPE;
            endcase
        end
    end

    feed_tick_decoder_sat_counter #(.W(CNT_W)) u_msg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (msg_inc),
        .cnt   (msg_cnt)
    );

    feed_tick_decoder_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );

endmodule
